morse_tone: RTL and testbench

MORSE_TONE -- requirements
Module: morse_tone

---
 rtl/morse_tone.sv | 147 ++++++++++++++
 tb/tb_morse_tone.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/morse_tone.sv
`default_nettype none
// ============================================================================
// Module      : morse_tone
// Description : Morse sounder. Converts a serial mark/space symbol stream
//               into a square-wave speaker drive. Tone onset is phase-aligned
//               to the mark; on release the current high half-period is
//               allowed to finish (DRAIN) so the speaker never gets a runt
//               pulse. Counts mark onsets in a saturating 8-bit counter.
//               Optional feature macro: MORSE_TONE_OCTAVE_EN adds input
//               octave_up, which halves the half-period when high.
// Ports       : clk         - system clock, rising-edge active
//               reset       - synchronous active-high reset
//               enable      - sounder enable (0 forces marks to spaces)
//               bit_in      - serial symbol, 1 = mark
//               clear_count - synchronous clear of mark_count
//               octave_up   - (MORSE_TONE_OCTAVE_EN only) octave select
//               audio_out   - square-wave speaker drive
//               active      - high whenever the FSM is not IDLE
//               mark_count  - saturating count of mark onsets
// Revision    : 1.0 - initial release
// ============================================================================
module morse_tone #(
    parameter int HALF_PERIOD = 56818,
    parameter int CNT_W       = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       bit_in,
    input  logic       clear_count,
`ifdef MORSE_TONE_OCTAVE_EN
    input  logic       octave_up,
`endif
    output logic       audio_out,
    output logic       active,
    output logic [7:0] mark_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TONE  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] c_reload_full = CNT_W'(HALF_PERIOD - 1);
`ifdef MORSE_TONE_OCTAVE_EN
    localparam logic [CNT_W-1:0] c_reload_half = CNT_W'((HALF_PERIOD >> 1) - 1);
`endif

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_audio;
    logic             r_active;
    logic             r_g_prev;
    logic [7:0]       r_mark_count;

    logic [1:0]       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_audio_next;
    logic             w_g;
    logic             w_expiry;
    logic             w_onset;
    logic [CNT_W-1:0] w_reload;

    assign w_g      = enable & bit_in;
    assign w_expiry = (r_cnt == '0);
    assign w_onset  = w_g & ~r_g_prev;

    // Reload value is chosen whenever the counter is (re)loaded, so an octave
    // change takes effect at the next half-period boundary, never mid-half.
`ifdef MORSE_TONE_OCTAVE_EN
    assign w_reload = octave_up ? c_reload_half : c_reload_full;
`else
    assign w_reload = c_reload_full;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_audio_next = r_audio;
        case (r_state)
            S_IDLE: begin
                w_cnt_next   = c_reload_full;
                w_audio_next = 1'b0;
                if (w_g) begin
                    w_state_next = S_TONE;
                    w_audio_next = 1'b1;
                    w_cnt_next   = w_reload;
                end
            end
            S_TONE, S_DRAIN: begin
                // A live mark (or staying in TONE) keeps the tone path, which
                // also wins over a DRAIN expiry in the same cycle.
                if ((r_state == S_TONE) || w_g) begin
                    w_state_next = w_g ? S_TONE : S_DRAIN;
                    if (w_expiry) begin
                        w_cnt_next   = w_reload;
                        w_audio_next = ~r_audio;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end else if (w_expiry) begin
                    // End of the half in progress: silence and go idle.
                    w_state_next = S_IDLE;
                    w_audio_next = 1'b0;
                    w_cnt_next   = c_reload_full;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_audio_next = 1'b0;
                w_cnt_next   = c_reload_full;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= c_reload_full;
            r_audio  <= 1'b0;
            r_active <= 1'b0;
            r_g_prev <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_audio  <= w_audio_next;
            r_active <= (w_state_next != S_IDLE);
            r_g_prev <= w_g;
        end
    end

    // Clear beats a coincident onset.
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            r_mark_count <= 8'd0;
        end else if (w_onset && (r_mark_count != 8'hFF)) begin
            r_mark_count <= r_mark_count + 8'd1;
        end
    end

    assign audio_out  = r_audio;
    assign active     = r_active;
    assign mark_count = r_mark_count;

endmodule
`default_nettype wire

// File: tb/tb_morse_tone.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_tone
// Description : Self-checking bench for morse_tone with HALF_PERIOD=4. A
//               behavioural reference model tracks elapsed cycles within each
//               half-period; its predictions are queued when inputs are
//               driven and compared after the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_tone;

    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       bit_in = 1'b0;
    logic       clear_count = 1'b0;
    logic       octave_up = 1'b0;
    logic       audio_out;
    logic       active;
    logic [7:0] mark_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    morse_tone #(.HALF_PERIOD(HP), .CNT_W(28)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .bit_in      (bit_in),
        .clear_count (clear_count),
`ifdef MORSE_TONE_OCTAVE_EN
        .octave_up   (octave_up),
`endif
        .audio_out   (audio_out),
        .active      (active),
        .mark_count  (mark_count)
    );

    typedef struct {
        logic       audio;
        logic       act;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];

    // Reference model: 0 idle, 1 tone, 2 drain
    int         m_state   = 0;
    logic       m_audio   = 1'b0;
    int         m_elapsed = 0;
    int         m_hp      = HP;
    logic       m_gprev   = 1'b0;
    logic [7:0] m_count   = 8'd0;

    task automatic model_step(input logic g, input logic clr, input logic rst, input logic oct);
        int  hp_new;
        logic expire;
        hp_new = oct ? (HP / 2) : HP;
        if (rst) begin
            m_state = 0; m_audio = 1'b0; m_elapsed = 0; m_hp = HP;
            m_gprev = 1'b0; m_count = 8'd0;
        end else begin
            if (clr) m_count = 8'd0;
            else if (g && !m_gprev && m_count < 8'd255) m_count = m_count + 8'd1;
            m_gprev = g;
            expire = (m_elapsed == m_hp - 1);
            if (m_state == 0) begin
                if (g) begin
                    m_state = 1; m_audio = 1'b1; m_elapsed = 0; m_hp = hp_new;
                end
            end else if (m_state == 1 || g) begin
                if (expire) begin
                    m_audio = ~m_audio; m_elapsed = 0; m_hp = hp_new;
                end else begin
                    m_elapsed++;
                end
                m_state = g ? 1 : 2;
            end else begin
                if (expire) begin
                    m_state = 0; m_audio = 1'b0; m_elapsed = 0; m_hp = HP;
                end else begin
                    m_elapsed++;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic en, input logic b, input logic clr, input logic rst, input logic oct);
        exp_t e;
        enable = en; bit_in = b; clear_count = clr; reset = rst; octave_up = oct;
        model_step(en & b, clr, rst, oct);
        sb.push_back('{m_audio, (m_state != 0), m_count});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("audio", {7'd0, audio_out}, {7'd0, e.audio});
        check("active", {7'd0, active}, {7'd0, e.act});
        check("mark_count", mark_count, e.cnt);
    endtask

    initial begin
        // Reset
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        check("reset_audio", {7'd0, audio_out}, 8'd0);
        check("reset_active", {7'd0, active}, 8'd0);
        check("reset_count", mark_count, 8'd0);

        // Enable off: marks ignored
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
        check("disabled_idle", {7'd0, active}, 8'd0);

        // Held mark: 1-cycle latency, toggles every HP cycles
        for (int i = 0; i < 20; i++) begin
            cycle(1, 1, 0, 0, 0);
            if (i == 0) check("rise_latency", {7'd0, audio_out}, 8'd1);
            if (i == 4) check("first_toggle", {7'd0, audio_out}, 8'd0);
        end
        check("tone_active", {7'd0, active}, 8'd1);
        check("one_onset", mark_count, 8'd1);

        // Advance to two cycles into a high half, then release
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 0, 0, 0);
            if (i < 2) check("drain_hold", {7'd0, audio_out}, 8'd1);
            if (i == 2) begin
                check("drain_end_audio", {7'd0, audio_out}, 8'd0);
                check("drain_end_active", {7'd0, active}, 8'd0);
            end
        end

        // Re-mark during DRAIN: phase continues, onset counted
        for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0);
        check("reentry_count", mark_count, 8'd3);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);

        // Saturation and clear
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 0, 0, 0);
            cycle(1, 0, 0, 0, 0);
        end
        check("saturated", mark_count, 8'd255);
        cycle(1, 0, 1, 0, 0);
        check("cleared", mark_count, 8'd0);
        // Clear coinciding with an onset
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0);
        check("clear_beats_onset", mark_count, 8'd0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);

        // Reset mid-tone with audio high
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        check("pre_reset_audio", {7'd0, audio_out}, 8'd1);
        cycle(1, 1, 0, 1, 0);
        check("midtone_reset_audio", {7'd0, audio_out}, 8'd0);
        check("midtone_reset_active", {7'd0, active}, 8'd0);
        check("midtone_reset_count", mark_count, 8'd0);
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);

`ifdef MORSE_TONE_OCTAVE_EN
        // Octave up: half-period of 2
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 0, 1);
            if (i == 2) check("octave_toggle", {7'd0, audio_out}, 8'd0);
        end
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
